// File: rtl/keypad_digit_tracker.sv
// keypad_digit_tracker: debounces the raw keypad_handler press flag and code,
// emits one new_key pulse per accepted press and keeps a two-deep digit history
// (digit_new / digit_old) for the seven-segment driver.
// Optional feature: define KEY_REPEAT_EN to re-commit a held key every
// REPEAT_CYCLES clocks (auto-repeat).
module keypad_digit_tracker #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_CYCLES   = 4000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pressed,
  input  logic [3:0] binout,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       new_key,
  output logic       held
);

`ifdef KEY_REPEAT_EN
  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                   DEBOUNCE_CYCLES : REPEAT_CYCLES;
`else
  localparam int unsigned CntMax = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
`else
  // REPEAT_CYCLES has no function without auto-repeat.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressDb = 2'd1;
  localparam logic [1:0] StHeld    = 2'd2;
  localparam logic [1:0] StRelDb   = 2'd3;

  logic            p_meta, p_s;
  logic [3:0]      code_meta, code_s;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      digit_new_q, digit_old_q;
  logic            new_key_q;
  logic            commit;
  logic            cnt_clr;

  // Two-flop synchronizers for the asynchronous keypad inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_meta    <= 1'b0;
      p_s       <= 1'b0;
      code_meta <= 4'd0;
      code_s    <= 4'd0;
    end else begin
      p_meta    <= pressed;
      p_s       <= p_meta;
      code_meta <= binout;
      code_s    <= code_meta;
    end
  end

  // Next-state, candidate capture and commit decision.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    commit  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      StIdle: begin
        if (p_s) begin
          cand_d  = code_s;
          state_d = StPressDb;
        end
      end
      StPressDb: begin
        // An abort wins over a counter that reaches its limit on the same cycle.
        if (!p_s || (code_s != cand_q)) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          commit  = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (!p_s) begin
          state_d = StRelDb;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt_q == RepLast) begin
          commit  = 1'b1;
          cnt_clr = 1'b1;
        end
`endif
      end
      StRelDb: begin
        if (p_s) begin
          state_d = StHeld;
        end else if (cnt_q == DbLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter clears on any transition (or repeat), otherwise saturates upward.
  always_comb begin
    if ((state_d != state_q) || cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_q != {CntW{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM, counter, history shift and event pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      digit_new_q <= 4'd0;
      digit_old_q <= 4'd0;
      new_key_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      new_key_q <= commit;
      if (commit) begin
        digit_old_q <= digit_new_q;
        digit_new_q <= cand_q;
      end
    end
  end

  // Outputs: held reflects the debounced key-down states.
  always_comb begin
    digit_new = digit_new_q;
    digit_old = digit_old_q;
    new_key   = new_key_q;
    held      = (state_q == StHeld) || (state_q == StRelDb);
  end

endmodule

// File: tb/tb_keypad_digit_tracker.sv
// Self-checking bench for keypad_digit_tracker (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32).
// A run-length model of the key behaviour is compared against the DUT every
// cycle; directed scenarios add hand-computed latency and history checks.
module tb_keypad_digit_tracker;
  localparam int unsigned Db  = 8;
  localparam int unsigned Rep = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       pressed;
  logic [3:0] binout;
  logic [3:0] digit_new, digit_old;
  logic       new_key, held;

  keypad_digit_tracker #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_CYCLES  (Rep)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pressed  (pressed),
    .binout   (binout),
    .digit_new(digit_new),
    .digit_old(digit_old),
    .new_key  (new_key),
    .held     (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the synchronized view is the input two edges ago; a
  // press is accepted after Db+1 consecutive edges of the same code, a release
  // after Db+1 consecutive edges of no key.
  bit       d1_p, d2_p, ps;
  bit [3:0] d1_c, d2_c, cs;
  bit [3:0] m_new, m_old, m_cand;
  bit       m_key, m_down;
  int       run, rel_run, rep_run;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1_p = 0; d2_p = 0; d1_c = 0; d2_c = 0;
      m_new = 0; m_old = 0; m_cand = 0; m_key = 0; m_down = 0;
      run = 0; rel_run = 0; rep_run = 0;
    end else begin
      ps = d2_p; cs = d2_c;
      d2_p = d1_p; d2_c = d1_c;
      d1_p = pressed; d1_c = binout;
      m_key = 0;
      if (!m_down) begin
        if (ps && run == 0) begin
          run = 1;
          m_cand = cs;
        end else if (ps && cs == m_cand) begin
          run++;
        end else begin
          run = 0;
        end
        if (run == Db + 1) begin
          m_old = m_new; m_new = m_cand; m_key = 1;
          m_down = 1; run = 0; rel_run = 0; rep_run = 0;
        end
      end else if (!ps) begin
        rel_run++;
        if (rel_run == Db + 1) begin
          m_down = 0;
          rel_run = 0;
        end
      end else if (rel_run > 0) begin
        rel_run = 0;
        rep_run = 0;
      end else begin
`ifdef KEY_REPEAT_EN
        rep_run++;
        if (rep_run == Rep) begin
          m_old = m_new; m_new = m_cand; m_key = 1;
          rep_run = 0;
        end
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("digit_new", int'(digit_new), int'(m_new));
    check("digit_old", int'(digit_old), int'(m_old));
    check("new_key", int'(new_key), int'(m_key));
    check("held", int'(held), int'(m_down));
    if (new_key === 1'b1) pulses++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (new_key !== 1'b1 && n <= max);
  endtask

  task automatic wait_held_low(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (held !== 1'b0 && n <= max);
  endtask

  task automatic press_release(input logic [3:0] code, input int hold, input int gap);
    pressed = 1'b1;
    binout  = code;
    idle(hold);
    pressed = 1'b0;
    idle(gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p0;
    reset   = 1'b0;
    pressed = 1'b0;
    binout  = 4'd0;

    // Reset
    idle(3);
    check("rst_digit_new", int'(digit_new), 0);
    check("rst_held", int'(held), 0);
    reset = 1'b1;
    idle(2);
    check("post_rst_new_key", int'(new_key), 0);
    check("post_rst_digit_old", int'(digit_old), 0);

    // Single key 0x5
    pressed = 1'b1;
    binout  = 4'h5;
    wait_pulse(30, n);
    check("single_latency", n, 11);
    check("single_new", int'(digit_new), 5);
    check("single_old", int'(digit_old), 0);
    idle(9);
    pressed = 1'b0;
    wait_held_low(30, n);
    check("release_latency", n, 11);
    idle(4);
    check("single_pulses", pulses, 1);

    // Bounce with code 0x9, then a stable hold
    binout = 4'h9;
    for (int i = 0; i < 10; i++) begin
      pressed = ~pressed;
      idle(3);
    end
    pressed = 1'b0;
    idle(6);
    check("bounce_pulses", pulses, 1);
    check("bounce_new", int'(digit_new), 5);
    press_release(4'h9, 20, 15);
    check("bounce_commit_pulses", pulses, 2);
    check("bounce_commit_new", int'(digit_new), 9);
    check("bounce_commit_old", int'(digit_old), 5);

    // History shift
    p0 = pulses;
    press_release(4'hA, 15, 15);
    press_release(4'h3, 15, 15);
    press_release(4'hF, 15, 15);
    check("hist_new", int'(digit_new), 15);
    check("hist_old", int'(digit_old), 3);
    check("hist_pulses", pulses - p0, 3);

    // Second key while held
    p0 = pulses;
    pressed = 1'b1;
    binout  = 4'h2;
    idle(12);
    binout  = 4'h7;
    idle(40);
    check("second_new", int'(digit_new), 2);
`ifndef KEY_REPEAT_EN
    check("second_pulses", pulses - p0, 1);
    check("second_old", int'(digit_old), 15);
`endif
    pressed = 1'b0;
    idle(15);

    // Reset mid-debounce with the key still held
    pressed = 1'b1;
    binout  = 4'h4;
    idle(6);
    #2 reset = 1'b0;
    #1;
    check("async_rst_new", int'(digit_new), 0);
    check("async_rst_held", int'(held), 0);
    check("async_rst_new_key", int'(new_key), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_pulse(30, n);
    check("rst_recommit_latency", n, 11);
    check("rst_recommit_new", int'(digit_new), 4);
    check("rst_recommit_old", int'(digit_old), 0);
    pressed = 1'b0;
    idle(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_digit_tracker.md
# keypad_digit_tracker

Debounce and history stage directly downstream of `keypad_handler`. Consumes its raw `pressed` flag and 4-bit `binout` code, and qualifies each stable press as exactly one key event. Maintains a two-deep history of accepted hex digits (newest and previous) for the dual seven-segment display driver. Holding a key, bouncing, or pressing a second key while one is held never produces extra events.

## Interface
- `DEBOUNCE_CYCLES`, 20000, number of clock cycles `pressed` must be stable before a press or release is accepted; legal values are ≥ 2.
- `REPEAT_CYCLES`, 4000000, auto-repeat period in cycles; used only when `KEY_REPEAT_EN` is defined.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pressed`  in  1  raw key-down flag from `keypad_handler`; may be asynchronous to `clk`.
- `binout`  in  4  raw key code from `keypad_handler`; meaningful only while `pressed` is 1.
- `digit_new`  out  4  most recently accepted key code.
- `digit_old`  out  4  previously accepted key code.
- `new_key`  out  1  one-cycle pulse on each accepted event.
- `held`  out  1  high while a debounced key is down.

## Operation
- **Synchronizer:** `pressed` and `binout` each pass through a 2-flop synchronizer. `p_s` and `code_s` denote the synchronized values. All FSM decisions use only `p_s` and `code_s`.
- **Counter:** `cnt`, width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1)`. It clears on every state transition and increments by 1 otherwise, saturating at its maximum. It never wraps.
- **Candidate register:** `cand`, 4 bits.
- **FSM:**
  - IDLE: if `p_s` is 1, load `cand <= code_s` and go to PRESS_DB.
  - PRESS_DB:
    - If `p_s` is 0, or `code_s != cand`, go to IDLE. No event is produced.
    - Otherwise, when `cnt == DEBOUNCE_CYCLES-1`: commit and go to HELD.
  - Commit: `digit_old <= digit_new`, `digit_new <= cand`, `new_key <= 1` for exactly one cycle.
  - HELD: if `p_s` is 0, go to REL_DB. A changed `code_s` is ignored, so a second key never commits.
  - REL_DB:
    - If `p_s` is 1 (any code), return to HELD with no commit.
    - If `cnt == DEBOUNCE_CYCLES-1`, go to IDLE.
- **`held`:** 1 in HELD and REL_DB, 0 in IDLE and PRESS_DB.
- **Reset values:**
  - State IDLE; `cnt`, `cand` = 0.
  - `digit_new` = 0, `digit_old` = 0.
  - `new_key` = 0, `held` = 0.
  - Synchronizer flops = 0.
- **Reset mid-operation:** asserting `reset` in any state returns all of the above immediately, without waiting for a clock edge. A press in progress is discarded. After deassertion, a still-held key must re-debounce from IDLE and then commits normally.

## Timing
- **Synchronizer latency:** an input change is visible to the FSM 2 rising edges after it settles.
- **Press latency:** IDLE→PRESS_DB occurs on edge 3. The commit occurs on edge `3+DEBOUNCE_CYCLES`. `digit_new`, `digit_old` and `new_key` all update on that same edge.
- **Event pulse:** `new_key` is high for exactly one cycle per commit, and is registered.
- **Release latency:** HELD→REL_DB on edge 3 after release; REL_DB→IDLE `DEBOUNCE_CYCLES` edges later. The minimum spacing between two accepted presses is therefore about `2*DEBOUNCE_CYCLES+6` cycles.
- **Simultaneous events:** a `p_s` drop on the same cycle that `cnt` reaches its limit in PRESS_DB counts as a bounce. Go to IDLE with no commit; the abort takes priority.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In HELD, `cnt` counts.
  - When `cnt == REPEAT_CYCLES-1`, re-commit `cand`: the shift is applied and `new_key` pulses. Then clear `cnt` and stay in HELD.
  - REL_DB→HELD also clears `cnt`.
- `KEY_REPEAT_EN` undefined:
  - HELD never commits and `cnt` is unused there.
  - `REPEAT_CYCLES` is ignored and excluded from the counter-width calculation.

## Test plan
Use `DEBOUNCE_CYCLES=8` and `REPEAT_CYCLES=32` for all scenarios.
- **Reset:** hold `reset=0`, then release it → all outputs read 0; `held=0`.
- **Single key:** clean press of 0x5 held for 20 cycles, then released →
  - `new_key` pulses once, exactly 11 edges after the press.
  - `digit_new=5`, `digit_old=0`; `held` returns to 0 about 11 cycles after release.
- **Bounce:** `pressed` toggles every 3 cycles for 30 cycles with code 0x9 → no `new_key` and digits unchanged; a subsequent stable hold commits exactly once.
- **History shift:** presses 0xA, then 0x3, then 0xF, each debounced →
  - After the last commit, `digit_new=F` and `digit_old=3`.
  - Exactly 3 `new_key` pulses were seen.
- **Second key while held:** hold 0x2; after it commits, change `binout` to 0x7 while `pressed` stays 1 → no new commit and `digit_new` stays 2.
  - With `KEY_REPEAT_EN`: one extra pulse every 32 cycles, each re-committing 2.
- **Reset mid-debounce:** pulse `reset` low during PRESS_DB with the key still held →
  - Outputs return to 0 asynchronously.
  - The key commits 11 edges after `reset` deasserts.
